// File: rtl/crc_pkg.sv
// Shared constants and types for the runtime CRC-32 slice-table generator.
// Holds the reflected polynomial and the generator FSM state encoding.
package crc_pkg;

    localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        WRITE = 2'd2,
        FIN   = 2'd3
    } gen_state_t;

    // Cycles needed to push one byte's worth of shift steps through the unrolled stage.
    function automatic int steps_per_byte(input int bits_per_cyc);
        return 8 / bits_per_cyc;
    endfunction

endpackage

// File: rtl/crc_shift_step.sv
// Purely combinational stage: applies BITS_PER_CYC reflected CRC shift steps
// to a 32-bit value, c = (c >> 1) ^ (c[0] ? POLY : 0) per step.
module crc_shift_step #(
    parameter logic [31:0] POLY         = crc_pkg::CRC32_POLY_REFL,
    parameter int          BITS_PER_CYC = 8
) (
    input  logic [31:0] i_crc,
    output logic [31:0] o_crc
);

    logic [31:0] w_acc;

    // NOTE: every variable driven here gets a value before any branch or loop,
    // so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_acc = i_crc;
        for (int i = 0; i < BITS_PER_CYC; i++) begin
            w_acc = (w_acc >> 1) ^ (w_acc[0] ? POLY : 32'h0);
        end
        o_crc = w_acc;
    end

endmodule

// File: rtl/crctab_gen.sv
// Runtime generator for sliced CRC-32 lookup tables: computes T_k[n] for n = 0..255
// and streams each entry to a table RAM through a valid/ready write port.
module crctab_gen
    import crc_pkg::*;
#(
    parameter logic [31:0] POLY         = CRC32_POLY_REFL,
    parameter int          BITS_PER_CYC = 8,
    parameter int          SLICE_W      = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [SLICE_W-1:0] slice,
    output logic               busy,
    output logic               done,
    output logic               wr_valid,
    input  logic               wr_ready,
    output logic [7:0]         wr_addr,
    output logic [31:0]        wr_data
);

    localparam int STEP_W = SLICE_W + 4;
    localparam logic [STEP_W-1:0] SPB = STEP_W'(steps_per_byte(BITS_PER_CYC));

    gen_state_t        r_state;
    gen_state_t        w_next_state;
    logic [7:0]        r_n;
    logic [31:0]       r_crc;
    logic [STEP_W-1:0] r_step;
    logic [STEP_W-1:0] r_last_step;
    logic              r_wr_valid;
    logic [31:0]       r_wr_data;

    logic [31:0]       w_crc_shifted;
    logic [STEP_W-1:0] w_slice_ext;
    logic [STEP_W-1:0] w_start_last;
    logic              w_last_step;
    logic              w_handshake;

    crc_shift_step #(
        .POLY         (POLY),
        .BITS_PER_CYC (BITS_PER_CYC)
    ) u_shift (
        .i_crc (r_crc),
        .o_crc (w_crc_shifted)
    );

    // Last step index for slice k is N-1 = (k+1)*(8/BITS_PER_CYC) - 1.
    assign w_slice_ext  = STEP_W'(slice);
    assign w_start_last = (w_slice_ext + STEP_W'(1)) * SPB - STEP_W'(1);
    assign w_last_step  = (r_step == r_last_step);
    assign w_handshake  = r_wr_valid & wr_ready;

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (start) w_next_state = SHIFT;
            SHIFT:   if (w_last_step) w_next_state = WRITE;
            WRITE:   if (w_handshake) w_next_state = (r_n == 8'hFF) ? FIN : SHIFT;
            FIN:     w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state == SHIFT) || (r_state == WRITE);
        done = (r_state == FIN);
    end

    assign wr_valid = r_wr_valid;
    assign wr_addr  = r_n;
    assign wr_data  = r_wr_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_n         <= 8'h00;
            r_crc       <= 32'h0;
            r_step      <= '0;
            r_last_step <= '0;
            r_wr_valid  <= 1'b0;
            r_wr_data   <= 32'h0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_n         <= 8'h00;
                        r_crc       <= 32'h0;
                        r_step      <= '0;
                        r_last_step <= w_start_last;
                    end
                end
                SHIFT: begin
                    r_crc  <= w_crc_shifted;
                    r_step <= r_step + STEP_W'(1);
                    if (w_last_step) begin
                        r_wr_data  <= w_crc_shifted;
                        r_wr_valid <= 1'b1;
                    end
                end
                WRITE: begin
                    // Entry 255 leaves n in place; completion never wraps the index.
                    if (w_handshake) begin
                        r_wr_valid <= 1'b0;
                        if (r_n != 8'hFF) begin
                            r_n    <= r_n + 8'd1;
                            r_crc  <= {24'h0, r_n + 8'd1};
                            r_step <= '0;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_crctab_gen.sv
// Directed bench for crctab_gen: known table constants, a recurrence-based
// reference for deeper slices, back-pressure, ignored start, reset abort, 1-bit stepping.
module tb_crctab_gen;
    import crc_pkg::*;

    typedef struct {
        int          k;
        int          n;
        logic [31:0] want;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, wr_ready;
    logic [3:0]  slice;
    logic        busy, done, wr_valid;
    logic [7:0]  wr_addr;
    logic [31:0] wr_data;

    logic        rst1, start1, wr_ready1;
    logic [3:0]  slice1;
    logic        busy1, done1, wr_valid1;
    logic [7:0]  wr_addr1;
    logic [31:0] wr_data1;

    crctab_gen #(.POLY(32'hEDB88320), .BITS_PER_CYC(8), .SLICE_W(4)) dut (
        .clk(clk), .rst(rst), .start(start), .slice(slice),
        .busy(busy), .done(done), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_addr(wr_addr), .wr_data(wr_data)
    );

    crctab_gen #(.POLY(32'hEDB88320), .BITS_PER_CYC(1), .SLICE_W(4)) dut1 (
        .clk(clk), .rst(rst1), .start(start1), .slice(slice1),
        .busy(busy1), .done(done1), .wr_valid(wr_valid1), .wr_ready(wr_ready1),
        .wr_addr(wr_addr1), .wr_data(wr_data1)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] tab [16][256];
    logic [31:0] ref1 [256];
    vec_t        vecs [10];

    logic [31:0] cap [256];
    int cap_cnt, order_err, done_cnt, done_cyc, s_cyc;
    logic [31:0] cap1 [256];
    int cap1_cnt, order_err1, space_err1, last_hs1, first_hs1, done1_cnt, done1_cyc, s1_cyc;

    // Handshakes are seen at the falling edge and complete at the next rising edge.
    always @(negedge clk) begin
        if (wr_valid && wr_ready) begin
            if (int'(wr_addr) != cap_cnt) order_err++;
            cap[wr_addr] = wr_data;
            cap_cnt++;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (wr_valid1 && wr_ready1) begin
            if (int'(wr_addr1) != cap1_cnt) order_err1++;
            if (cap1_cnt == 0) first_hs1 = cyc;
            else if (cyc - last_hs1 != 17) space_err1++;
            last_hs1 = cyc;
            cap1[wr_addr1] = wr_data1;
            cap1_cnt++;
        end
        if (done1) begin
            done1_cnt++;
            done1_cyc = cyc;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, want);
        end
    endtask

    function automatic logic [31:0] serial8(input logic [31:0] c);
        logic [31:0] v = c;
        for (int i = 0; i < 8; i++) v = v[0] ? ((v >> 1) ^ 32'hEDB88320) : (v >> 1);
        return v;
    endfunction

    function automatic int tab_errs(input int k);
        int e = 0;
        for (int n = 0; n < 256; n++) if (cap[n] !== tab[k][n]) e++;
        return e;
    endfunction

    task automatic clear_cap();
        for (int n = 0; n < 256; n++) cap[n] = 32'hx;
        cap_cnt = 0; order_err = 0; done_cnt = 0; done_cyc = -1;
    endtask

    task automatic pulse_start(input logic [3:0] k);
        @(posedge clk); #1;
        slice = k; start = 1'b1; s_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        for (int i = 0; i < budget && done_cnt == 0; i++) begin
            @(posedge clk); #1;
        end
        check({name, " done seen"}, 32'(done_cnt > 0), 32'd1);
    endtask

    task automatic wait_addr(input logic [7:0] a, input int budget);
        bit ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(posedge clk); #1;
            if (wr_addr == a) ok = 1'b1;
        end
        check($sformatf("reach addr %0d", a), 32'(ok), 32'd1);
    endtask

    task automatic apply_vectors(input int k);
        for (int i = 0; i < 10; i++) begin
            if (vecs[i].k == k)
                check($sformatf("T%0d[%0d]", k, vecs[i].n), cap[vecs[i].n], vecs[i].want);
        end
    endtask

    task automatic check_run(input string name, input int k, input int latency);
        check({name, " writes"}, cap_cnt, 256);
        check({name, " order"}, order_err, 0);
        check({name, " done pulses"}, done_cnt, 1);
        check({name, " latency"}, done_cyc - s_cyc, latency);
        check({name, " table"}, tab_errs(k), 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; slice = '0; wr_ready = 1'b1;
        rst1 = 1'b1; start1 = 1'b0; slice1 = '0; wr_ready1 = 1'b1;

        for (int n = 0; n < 256; n++) tab[0][n] = serial8(32'(n));
        for (int k = 1; k < 16; k++)
            for (int n = 0; n < 256; n++)
                tab[k][n] = tab[0][tab[k-1][n][7:0]] ^ (tab[k-1][n] >> 8);

        vecs[0] = '{k: 0, n: 8'h00, want: 32'h00000000};
        vecs[1] = '{k: 0, n: 8'h01, want: 32'h77073096};
        vecs[2] = '{k: 0, n: 8'h02, want: 32'hEE0E612C};
        vecs[3] = '{k: 0, n: 8'h03, want: 32'h990951BA};
        vecs[4] = '{k: 0, n: 8'h04, want: 32'h076DC419};
        vecs[5] = '{k: 0, n: 8'h08, want: 32'h0EDB8832};
        vecs[6] = '{k: 0, n: 8'h10, want: 32'h1DB71064};
        vecs[7] = '{k: 0, n: 8'h80, want: 32'hEDB88320};
        vecs[8] = '{k: 0, n: 8'hFF, want: 32'h2D02EF8D};
        vecs[9] = '{k: 9, n: 8'h00, want: 32'h00000000};

        clear_cap();
        cap1_cnt = 0; order_err1 = 0; space_err1 = 0; last_hs1 = 0; first_hs1 = -1;
        done1_cnt = 0; done1_cyc = -1;

        repeat (3) @(posedge clk);
        #1;
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset wr_valid", 32'(wr_valid), 32'd0);
        check("reset wr_addr", 32'(wr_addr), 32'd0);
        check("reset wr_data", wr_data, 32'd0);
        rst = 1'b0; rst1 = 1'b0;

        // Slice 0 with the RAM always ready.
        clear_cap();
        pulse_start(4'd0);
        check("t1 busy", 32'(busy), 32'd1);
        wait_done("t1", 2000);
        check_run("t1", 0, 513);
        apply_vectors(0);
        check("t1 idle busy", 32'(busy), 32'd0);

        // Deep slice against the byte-recurrence reference.
        clear_cap();
        pulse_start(4'd9);
        wait_done("t2", 4000);
        check_run("t2", 9, 2817);
        apply_vectors(9);

        // Back-pressure at n=3.
        clear_cap();
        pulse_start(4'd0);
        wait_addr(8'd3, 100);
        wr_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check($sformatf("stall%0d valid", i), 32'(wr_valid), 32'd1);
            check($sformatf("stall%0d addr", i), 32'(wr_addr), 32'd3);
            check($sformatf("stall%0d data", i), wr_data, 32'h990951BA);
        end
        check("stall writes so far", cap_cnt, 3);
        wr_ready = 1'b1;
        wait_done("t3", 2000);
        check("t3 writes", cap_cnt, 256);
        check("t3 order", order_err, 0);
        check("t3 done pulses", done_cnt, 1);
        check("t3 table", tab_errs(0), 0);

        // A second start mid-run must be ignored, including its slice.
        clear_cap();
        pulse_start(4'd0);
        wait_addr(8'd50, 300);
        start = 1'b1; slice = 4'd5;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done("t4", 2000);
        check_run("t4", 0, 513);
        repeat (20) @(posedge clk);
        #1;
        check("t4 no extra done", done_cnt, 1);
        check("t4 no extra writes", cap_cnt, 256);
        check("t4 idle busy", 32'(busy), 32'd0);

        // Reset at n=100 with start asserted together: reset wins.
        clear_cap();
        pulse_start(4'd0);
        wait_addr(8'd100, 400);
        rst = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0;
        check("rst busy", 32'(busy), 32'd0);
        check("rst wr_valid", 32'(wr_valid), 32'd0);
        check("rst state", 32'(dut.r_state), 32'(IDLE));
        repeat (20) @(posedge clk);
        #1;
        check("rst writes frozen", cap_cnt, 100);
        check("rst no done", done_cnt, 0);
        check("rst stays idle", 32'(busy), 32'd0);
        clear_cap();
        pulse_start(4'd1);
        wait_done("t5", 2000);
        check_run("t5", 1, 769);
        for (int n = 0; n < 256; n++) ref1[n] = cap[n];

        // One-bit-per-cycle instance must match the byte-wide results.
        @(posedge clk); #1;
        slice1 = 4'd1; start1 = 1'b1; s1_cyc = cyc;
        @(posedge clk); #1;
        start1 = 1'b0;
        for (int i = 0; i < 6000 && done1_cnt == 0; i++) begin
            @(posedge clk); #1;
        end
        check("t6 done seen", 32'(done1_cnt > 0), 32'd1);
        check("t6 writes", cap1_cnt, 256);
        check("t6 order", order_err1, 0);
        check("t6 spacing", space_err1, 0);
        check("t6 first write", first_hs1 - s1_cyc, 17);
        check("t6 latency", done1_cyc - s1_cyc, 4353);
        begin
            int e = 0;
            for (int n = 0; n < 256; n++) if (cap1[n] !== ref1[n]) e++;
            check("t6 vs byte-wide", e, 0);
        end
        begin
            int e = 0;
            for (int n = 0; n < 256; n++) if (cap1[n] !== tab[1][n]) e++;
            check("t6 table", e, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
